// File: rtl/BrLitePkg.sv
// Shared BrLite types: flit layout, service codes and the NI transmit request record.
package BrLitePkg;

  localparam int unsigned BR_ADDR_W    = 16;
  localparam int unsigned BR_SVC_W     = 2;
  localparam int unsigned BR_PAYLOAD_W = 16;
  localparam int unsigned BR_ID_W      = 4;

  localparam logic [BR_SVC_W-1:0] BR_SVC_ALL   = 2'd0;
  localparam logic [BR_SVC_W-1:0] BR_SVC_TGT   = 2'd1;
  localparam logic [BR_SVC_W-1:0] BR_SVC_CLEAR = 2'd2;
  localparam logic [BR_SVC_W-1:0] BR_SVC_RSVD  = 2'd3;

  typedef struct packed {
    logic [BR_ADDR_W-1:0]    source;
    logic [BR_ADDR_W-1:0]    target;
    logic [BR_SVC_W-1:0]     service;
    logic [BR_PAYLOAD_W-1:0] payload;
    logic [BR_ID_W-1:0]      id;
  } br_data_t;

  typedef struct packed {
    logic [BR_SVC_W-1:0]     service;
    logic [BR_ADDR_W-1:0]    target;
    logic [BR_PAYLOAD_W-1:0] payload;
  } br_ni_tx_req_t;

  // Only broadcast and targeted services may be launched by a PE.
  function automatic logic br_svc_launchable(input logic [BR_SVC_W-1:0] svc);
    return (svc == BR_SVC_ALL) || (svc == BR_SVC_TGT);
  endfunction

endpackage

// File: rtl/br_ni_fifo.sv
// First-word-fall-through FIFO, no bypass; push is ignored when full, pop when empty.
module br_ni_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/br_lite_ni.sv
// BrLite local network interface: PE valid/ready streams <-> router four-phase req/ack.
// Optional BR_NI_STATS_EN adds saturating TX-handshake and RX-push counters.
module br_lite_ni
  import BrLitePkg::*;
#(
  parameter logic [BR_ADDR_W-1:0] ADDRESS  = 16'h0000,
  parameter int unsigned          TX_DEPTH = 4,
  parameter int unsigned          RX_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  input  logic [BR_SVC_W-1:0]     tx_service_i,
  input  logic [BR_ADDR_W-1:0]    tx_target_i,
  input  logic [BR_PAYLOAD_W-1:0] tx_payload_i,
  output logic                    tx_err_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output br_data_t                rx_data_o,
  output br_data_t                br_flit_o,
  output logic                    br_req_o,
  input  logic                    br_ack_i,
  input  logic                    br_busy_i,
  input  br_data_t                br_flit_i,
  input  logic                    br_req_i,
  output logic                    br_ack_o
`ifdef BR_NI_STATS_EN
  ,
  output logic [31:0]             tx_count_o,
  output logic [31:0]             rx_count_o
`endif
);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_state_e;
  typedef enum logic {RX_IDLE, RX_ACK} rx_state_e;

  tx_state_e          tx_state_q, tx_state_d;
  rx_state_e          rx_state_q, rx_state_d;
  br_data_t           flit_q, flit_d;
  logic [BR_ID_W-1:0] id_q, id_d;
  logic               err_q, err_d;

  br_ni_tx_req_t tx_req, tx_head;
  logic          tx_full, tx_empty, tx_pop;
  logic          rx_full, rx_empty, rx_push;

  assign tx_req = '{service: tx_service_i, target: tx_target_i, payload: tx_payload_i};

  br_ni_fifo #(.WIDTH($bits(br_ni_tx_req_t)), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (tx_valid_i),
    .data_i (tx_req),
    .pop_i  (tx_pop),
    .data_o (tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty)
  );

  br_ni_fifo #(.WIDTH($bits(br_data_t)), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (rx_push),
    .data_i (br_flit_i),
    .pop_i  (rx_ready_i),
    .data_o (rx_data_o),
    .full_o (rx_full),
    .empty_o(rx_empty)
  );

  assign tx_ready_o = !tx_full;
  assign rx_valid_o = !rx_empty;
  assign tx_err_o   = err_q;
  assign br_flit_o  = flit_q;
  assign br_req_o   = (tx_state_q == TX_REQ);
  assign br_ack_o   = (rx_state_q == RX_ACK);

  // TX: launch only when the router's local broadcast window is clear.
  always_comb begin
    tx_state_d = tx_state_q;
    flit_d     = flit_q;
    id_d       = id_q;
    err_d      = 1'b0;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !br_busy_i) begin
          tx_pop = 1'b1;
          if (br_svc_launchable(tx_head.service)) begin
            flit_d = '{source:  ADDRESS,
                       target:  tx_head.target,
                       service: tx_head.service,
                       payload: tx_head.payload,
                       id:      id_q};
            id_d       = id_q + BR_ID_W'(1);
            tx_state_d = TX_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      TX_REQ:  if (br_ack_i)  tx_state_d = TX_WAIT;
      TX_WAIT: if (!br_ack_i) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX: ack is withheld while the FIFO is full, which stalls the router.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_push    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (br_req_i && !rx_full) begin
          rx_push    = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK:  if (!br_req_i) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      flit_q     <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      flit_q     <= flit_d;
      id_q       <= id_d;
      err_q      <= err_d;
    end
  end

`ifdef BR_NI_STATS_EN
  logic [31:0] tx_cnt_q, rx_cnt_q;
  logic        tx_done;

  assign tx_done    = (tx_state_q == TX_WAIT) && !br_ack_i;
  assign tx_count_o = tx_cnt_q;
  assign rx_count_o = rx_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_done && (tx_cnt_q != '1)) tx_cnt_q <= tx_cnt_q + 32'd1;
      if (rx_push && (rx_cnt_q != '1)) rx_cnt_q <= rx_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: doc/br_lite_ni.md
# br_lite_ni

Local network interface for a BrLite router. It converts processing-element (PE) valid/ready streams into the router's local-port four-phase req/ack broadcast handshake, in both directions. It sits between the PE and the router's BR_LOCAL port. On transmit it builds the full flit (source = ADDRESS, auto-incremented id) and respects the router's local-busy window. On receive it buffers delivered flits and applies backpressure to the router by withholding ack.

## Interface
- ADDRESS, 16'h0000 — this node's address; inserted as the source field of every transmitted flit.
- TX_DEPTH, 4 — TX FIFO entries; power of two, ≥2.
- RX_DEPTH, 4 — RX FIFO entries; power of two, ≥2.

- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- tx_valid_i  in  1  PE transmit request valid.
- tx_ready_o  out  1  TX FIFO not full.
- tx_service_i  in  service width of br_data_t  requested service.
- tx_target_i  in  16  target address.
- tx_payload_i  in  payload width of br_data_t  payload.
- tx_err_o  out  1  one-cycle pulse: an accepted request carried an illegal service and was dropped.
- rx_valid_o  out  1  RX FIFO not empty.
- rx_ready_i  in  1  PE pops the RX FIFO head.
- rx_data_o  out  br_data_t  RX FIFO head.
- br_flit_o  out  br_data_t  flit to the router local input.
- br_req_o  out  1  request to the router local input.
- br_ack_i  in  1  ack from the router local input.
- br_busy_i  in  1  router local_busy (a local broadcast is still awaiting its clear).
- br_flit_i  in  br_data_t  flit from the router local output.
- br_req_i  in  1  request from the router local output.
- br_ack_o  out  1  ack to the router local output.

## Operation
- TX FIFO:
  - PE push when tx_valid_i && tx_ready_o.
  - Entry holds service, target and payload.
- TX FSM:
  - TX_IDLE:
    - Waits for the FIFO to be non-empty and !br_busy_i.
    - Then pops the head.
    - If the head service is BR_SVC_ALL or BR_SVC_TGT:
      - latches br_flit_o = {source=ADDRESS, target, service, payload, id=id_cnt};
      - increments id_cnt (wraps modulo the id width);
      - goes to TX_REQ.
    - Any other service: pulses tx_err_o, stays in TX_IDLE, id_cnt unchanged.
  - TX_REQ: br_req_o=1; on br_ack_i=1 goes to TX_WAIT.
  - TX_WAIT: br_req_o=0; on br_ack_i=0 goes to TX_IDLE.
- RX FSM:
  - RX_IDLE:
    - When br_req_i=1 and the RX FIFO is not full: pushes br_flit_i and goes to RX_ACK.
    - When the RX FIFO is full: stays in RX_IDLE, ack is withheld, and the router stalls.
  - RX_ACK: br_ack_o=1; on br_req_i=0 goes to RX_IDLE.
  - Exactly one push per handshake.
  - This compatibility holds for both router delivery modes:
    - Dedicated local delivery: router holds req until ack, then waits for ack to fall.
    - Broadcast fan-out: router drops req the cycle after ack.
- RX FIFO: PE pop when rx_valid_i... specifically rx_valid_o && rx_ready_i.
- Both FIFOs are first-word-fall-through. The head is valid the cycle after the push.

## Timing
- Reset values:
  - br_req_o=0, br_ack_o=0, br_flit_o='0;
  - tx_ready_o=1, tx_err_o=0, rx_valid_o=0;
  - id_cnt=0; both FIFOs empty; both FSMs idle.
- br_req_o, br_ack_o and br_flit_o are registered, Moore-decoded from state. There is no combinational path from any input.
- TX latency: push at cycle 0 into an empty FIFO with br_busy_i=0 → br_req_o=1 at cycle 2.
- RX latency: br_req_i=1 at cycle 0 with space → br_ack_o=1 at cycle 1, rx_valid_o=1 at cycle 1.
- br_ack_o falls the cycle after br_req_i=0 is sampled.
- br_flit_o stays stable from TX_REQ entry until the next latch.
- Full/empty:
  - No bypass in either FIFO.
  - A full RX FIFO blocks acceptance even if the PE pops in the same cycle; acceptance happens the next cycle.
  - A full TX FIFO deasserts tx_ready_o; a simultaneous pop and push is allowed only when not full.
- br_busy_i rising while in TX_REQ or TX_WAIT does not abort the handshake. It only gates the next launch.
- Reset mid-handshake: all state returns to reset values immediately.

## Configuration
- BR_NI_STATS_EN defined:
  - Adds outputs tx_count_o[31:0] (completed TX handshakes) and rx_count_o[31:0] (RX pushes).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- BrLitePkg supplies br_data_t, the service constants and br_ni_tx_req_t (service, target, payload), the new addition for this block.
- FSM enums are local to br_lite_ni.
- Sub-module br_ni_fifo: parameterised width/depth, FWFT, full/empty flags. It is instantiated once for TX and once for RX.

## Test plan
- Single ALL broadcast: push {ALL, 0x0102, payload 0x55}; the bench acks after 3 cycles → br_flit_o = {source ADDRESS, id 0}, br_req_o falls the cycle after ack, id_cnt=1.
- Busy gating: br_busy_i=1, push two TGT requests → br_req_o stays 0. Release busy → flits go out in order with ids 0 and 1.
- Illegal service: push a CLEAR request → tx_err_o pulses once, no br_req_o, id_cnt unchanged.
- RX full: RX_DEPTH=4, rx_ready_i=0, router drives 5 deliveries:
  - 4 are acked;
  - the 5th leaves br_ack_o=0 with br_req_i held;
  - one pop → the 5th is acked the following cycle, and data order is preserved.
- Fan-out style RX: br_req_i drops the cycle after ack → br_ack_o falls the next cycle, exactly one push.
- Reset asserted in TX_REQ → br_req_o=0 and FIFOs empty immediately. After release, a new push goes out with id 0.
